image_frame_loader: RTL and testbench

- Upstream feeder for the TPU controller.
- Accepts an 8-bit grayscale raster pixel stream of a 32x32 image and thresholds each pixel to 1 bit into a capture buffer.
- On frame completion it freezes the frame onto the 1024-bit image bus, sequences the TPU controller's enable/reset, waits for its done, and latches the classified digit.
- Sits between the pixel source (camera/UART/draw-pad adapter) and the TPU controller.

---
 rtl/image_frame_loader_pkg.sv | 25 ++
 rtl/image_frame_loader_pixel_threshold.sv | 15 +
 rtl/image_frame_loader.sv | 158 +++++++++++++++
 tb/tb_image_frame_loader.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/image_frame_loader_pkg.sv
// image_frame_loader_pkg
//   Shared types and constants for the image frame loader.
//   - state_t      : loader FSM encoding (IDLE, LOAD, KICK, RUN)
//   - IMG_W        : image edge length in pixels (square image)
//   - IMG_BITS     : number of 1-bit pixels in a frame
//   - IDX_W        : width of the raster pixel index
//   - NO_RESULT    : result_num value before any classification
//   - TIMEOUT_CODE : result_num value after the TPU failed to finish
package image_frame_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_KICK = 2'd2,
    ST_RUN  = 2'd3
  } state_t;

  localparam int IMG_W    = 32;
  localparam int IMG_BITS = IMG_W * IMG_W;
  localparam int IDX_W    = $clog2(IMG_BITS);

  localparam logic [3:0] NO_RESULT    = 4'hF;
  localparam logic [3:0] TIMEOUT_CODE = 4'hE;

endpackage

// File: rtl/image_frame_loader_pixel_threshold.sv
// pixel_threshold
//   Binarises one grayscale pixel.
//   Ports:
//     pix_data : 8-bit grayscale pixel
//     pix_bit  : 1 when pix_data >= THRESH, else 0
module pixel_threshold #(
  parameter logic [7:0] THRESH = 8'd128
) (
  input  logic [7:0] pix_data,
  output logic       pix_bit
);

  assign pix_bit = (pix_data >= THRESH);

endmodule

// File: rtl/image_frame_loader.sv
// image_frame_loader
//   Captures a 32x32 grayscale raster stream as a 1-bit image, freezes the
//   completed frame onto tpu_image, kicks the TPU controller (reset pulse,
//   then enable), waits for done or a timeout and latches the result.
//   Ports:
//     clk, iRst          : clock, synchronous active-high reset
//     pix_valid/pix_data : pixel stream in, pix_sof marks pixel (0,0)
//     pix_ready          : loader accepts a pixel this cycle
//     tpu_image          : frozen frame, bit index = row*32+col
//     tpu_ena, tpu_rst_n : TPU controller enable / active-low reset
//     tpu_done, tpu_num, tpu_overflow : TPU controller result
//     result_num, result_overflow     : latched result (F = none, E = timeout)
//     result_valid       : one-cycle pulse when result_* updates
//     timeout_err        : sticky timeout flag, cleared by next accepted SOF
//     busy               : high while the TPU is being kicked or running
//
//   Pixel handshake: a pixel transfers on a rising edge where pix_valid and
//   pix_ready are both 1. pix_ready depends on the FSM state only (never on
//   pix_valid); the source must hold the pixel while pix_ready is 0.
module image_frame_loader
  import image_frame_loader_pkg::*;
#(
  parameter logic [7:0]  THRESH     = 8'd128,
  parameter int          RST_CYCLES = 2,
  parameter logic [19:0] TIMEOUT    = 20'd1000000
) (
  input  logic                clk,
  input  logic                iRst,
  input  logic                pix_valid,
  input  logic [7:0]          pix_data,
  input  logic                pix_sof,
  output logic                pix_ready,
  output logic [IMG_BITS-1:0] tpu_image,
  output logic                tpu_ena,
  output logic                tpu_rst_n,
  input  logic                tpu_done,
  input  logic [3:0]          tpu_num,
  input  logic                tpu_overflow,
  output logic [3:0]          result_num,
  output logic                result_overflow,
  output logic                result_valid,
  output logic                timeout_err,
  output logic                busy
);

  localparam int KICK_W = $clog2(RST_CYCLES + 1);
  localparam int CNT_W  = (TIMEOUT > 20'd1) ? $clog2(TIMEOUT) : 1;

  state_t              state, state_next;
  logic [IDX_W-1:0]    idx;
  logic [IMG_BITS-1:0] cap_buf, buf_next;
  logic [KICK_W-1:0]   kick_cnt;
  logic [CNT_W-1:0]    run_cnt;
  logic                pix_bit;
  logic                accept, sof_accept;
  logic                frame_done, done_hit, timeout_hit;

  pixel_threshold #(.THRESH(THRESH)) u_thresh (
    .pix_data (pix_data),
    .pix_bit  (pix_bit)
  );

  assign pix_ready  = (state == ST_IDLE) || (state == ST_LOAD);
  assign accept     = pix_valid & pix_ready;
  assign sof_accept = accept & pix_sof;
  assign busy       = (state == ST_KICK) || (state == ST_RUN);
  assign tpu_ena    = busy;
  assign tpu_rst_n  = (state != ST_KICK);

  always_comb begin
    state_next  = state;
    buf_next    = cap_buf;
    frame_done  = 1'b0;
    done_hit    = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      ST_IDLE: begin
        // Pixels without SOF are dropped until a frame start shows up.
        if (sof_accept) begin
          buf_next[0] = pix_bit;
          state_next  = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (accept) begin
          if (pix_sof) begin
            // Restart: remaining bits keep stale data until rewritten.
            buf_next[0] = pix_bit;
          end else begin
            buf_next[idx] = pix_bit;
            if (idx == IDX_W'(IMG_BITS - 1)) begin
              frame_done = 1'b1;
              state_next = ST_KICK;
            end
          end
        end
      end
      ST_KICK: begin
        if (kick_cnt == KICK_W'(RST_CYCLES - 1)) state_next = ST_RUN;
      end
      ST_RUN: begin
        // Done in the first RUN cycle may be left over from a previous run.
        if (tpu_done && (run_cnt != '0)) begin
          done_hit   = 1'b1;
          state_next = ST_IDLE;
        end else if (run_cnt == CNT_W'(TIMEOUT - 20'd1)) begin
          timeout_hit = 1'b1;
          state_next  = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (iRst) begin
      state           <= ST_IDLE;
      idx             <= '0;
      cap_buf         <= '0;
      tpu_image       <= '0;
      kick_cnt        <= '0;
      run_cnt         <= '0;
      result_num      <= NO_RESULT;
      result_overflow <= 1'b0;
      result_valid    <= 1'b0;
      timeout_err     <= 1'b0;
    end else begin
      state        <= state_next;
      cap_buf      <= buf_next;
      result_valid <= 1'b0;

      if (sof_accept) begin
        idx         <= IDX_W'(1);
        timeout_err <= 1'b0;
      end else if (accept && (state == ST_LOAD)) begin
        // Wraps from 1023 back to 0 on frame completion.
        idx <= idx + 1'b1;
      end

      // tpu_image only changes here, so it is stable through KICK and RUN.
      if (frame_done) tpu_image <= buf_next;

      kick_cnt <= (state == ST_KICK) ? kick_cnt + 1'b1 : '0;
      run_cnt  <= (state == ST_RUN)  ? run_cnt + 1'b1  : '0;

      if (done_hit) begin
        result_num      <= tpu_num;
        result_overflow <= tpu_overflow;
        result_valid    <= 1'b1;
      end else if (timeout_hit) begin
        result_num   <= TIMEOUT_CODE;
        timeout_err  <= 1'b1;
        result_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_image_frame_loader.sv
// tb_image_frame_loader
//   Directed bench for image_frame_loader (TIMEOUT overridden to 100).
module tb_image_frame_loader;
  import image_frame_loader_pkg::*;

  logic                clk = 1'b0;
  logic                iRst;
  logic                pix_valid;
  logic [7:0]          pix_data;
  logic                pix_sof;
  logic                pix_ready;
  logic [IMG_BITS-1:0] tpu_image;
  logic                tpu_ena;
  logic                tpu_rst_n;
  logic                tpu_done;
  logic [3:0]          tpu_num;
  logic                tpu_overflow;
  logic [3:0]          result_num;
  logic                result_overflow;
  logic                result_valid;
  logic                timeout_err;
  logic                busy;

  int checks   = 0;
  int failures = 0;

  logic [7:0]          frame_pix [IMG_BITS];
  logic [IMG_BITS-1:0] exp_q [$];
  logic [IMG_BITS-1:0] last_img;
  logic [IMG_BITS-1:0] img_a;
  logic                seen_pulse;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  image_frame_loader #(
    .THRESH     (8'd128),
    .RST_CYCLES (2),
    .TIMEOUT    (20'd100)
  ) dut (
    .clk             (clk),
    .iRst            (iRst),
    .pix_valid       (pix_valid),
    .pix_data        (pix_data),
    .pix_sof         (pix_sof),
    .pix_ready       (pix_ready),
    .tpu_image       (tpu_image),
    .tpu_ena         (tpu_ena),
    .tpu_rst_n       (tpu_rst_n),
    .tpu_done        (tpu_done),
    .tpu_num         (tpu_num),
    .tpu_overflow    (tpu_overflow),
    .result_num      (result_num),
    .result_overflow (result_overflow),
    .result_valid    (result_valid),
    .timeout_err     (timeout_err),
    .busy            (busy)
  );

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [IMG_BITS-1:0] obs,
                       input logic [IMG_BITS-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_pixel(input logic [7:0] d, input logic sof);
    @(negedge clk);
    pix_valid = 1'b1;
    pix_data  = d;
    pix_sof   = sof;
  endtask

  // Sends frame_pix with SOF on pixel 0; returns at the first negedge
  // after the last pixel transferred, inputs idle.
  task automatic send_frame();
    logic [IMG_BITS-1:0] e;
    for (int i = 0; i < IMG_BITS; i++) begin
      e[i] = (frame_pix[i] >= 8'd128);
      drive_pixel(frame_pix[i], (i == 0));
    end
    exp_q.push_back(e);
    @(negedge clk);
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
  endtask

  // Called at the first KICK negedge; returns at the first RUN negedge.
  task automatic kick_to_run(input string tag);
    logic [IMG_BITS-1:0] e;
    e = exp_q.pop_front();
    last_img = e;
    check({tag, "_image"}, tpu_image, e);
    check({tag, "_kick1_ready"}, pix_ready, 1'b0);
    check({tag, "_kick1_rstn"}, tpu_rst_n, 1'b0);
    check({tag, "_kick1_ena"}, tpu_ena, 1'b1);
    @(negedge clk);
    check({tag, "_kick2_rstn"}, tpu_rst_n, 1'b0);
    @(negedge clk);
    check({tag, "_run_rstn"}, tpu_rst_n, 1'b1);
    check({tag, "_run_busy"}, busy, 1'b1);
  endtask

  // Called at a RUN negedge; raises done after `delay` cycles.
  task automatic finish_run(input string tag, input int delay,
                            input logic [3:0] num, input logic ovf);
    repeat (delay) @(negedge clk);
    tpu_done     = 1'b1;
    tpu_num      = num;
    tpu_overflow = ovf;
    @(negedge clk);
    tpu_done = 1'b0;
    check({tag, "_rv"}, result_valid, 1'b1);
    check({tag, "_num"}, result_num, num);
    check({tag, "_ovf"}, result_overflow, ovf);
    check({tag, "_ena_low"}, tpu_ena, 1'b0);
    check({tag, "_ready_back"}, pix_ready, 1'b1);
    @(negedge clk);
    check({tag, "_rv_pulse_end"}, result_valid, 1'b0);
    check({tag, "_image_hold"}, tpu_image, last_img);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    iRst = 1'b1; pix_valid = 1'b0; pix_data = 8'd0; pix_sof = 1'b0;
    tpu_done = 1'b0; tpu_num = 4'd0; tpu_overflow = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_image", tpu_image, '0);
    check("rst_ena", tpu_ena, 1'b0);
    check("rst_rstn", tpu_rst_n, 1'b1);
    check("rst_num", result_num, 4'hF);
    check("rst_ovf", result_overflow, 1'b0);
    check("rst_rv", result_valid, 1'b0);
    check("rst_terr", timeout_err, 1'b0);
    check("rst_ready", pix_ready, 1'b1);
    iRst = 1'b0;

    // Alternating dark/bright pixels -> {512{2'b10}}
    for (int i = 0; i < IMG_BITS; i++) frame_pix[i] = (i % 2) ? 8'd200 : 8'd10;
    img_a = {512{2'b10}};
    send_frame();
    check("a_const_image", tpu_image, img_a);
    kick_to_run("a");
    finish_run("a", 50, 4'd7, 1'b1);

    // Threshold boundaries at both ends of the frame
    for (int i = 0; i < IMG_BITS; i++) frame_pix[i] = (i % 5 == 0) ? 8'd128 : 8'd127;
    frame_pix[0]    = 8'd127;
    frame_pix[1023] = 8'd128;
    send_frame();
    check("b_bit0", tpu_image[0], 1'b0);
    check("b_bit1023", tpu_image[1023], 1'b1);
    kick_to_run("b");
    // Done in the first RUN cycle must be ignored
    tpu_done = 1'b1; tpu_num = 4'd9; tpu_overflow = 1'b0;
    @(negedge clk);
    tpu_done = 1'b0;
    check("b_stale_done_rv", result_valid, 1'b0);
    check("b_stale_done_ena", tpu_ena, 1'b1);
    finish_run("b", 5, 4'd3, 1'b0);

    // A full frame's worth of pixels without SOF is discarded
    for (int i = 0; i < IMG_BITS; i++) drive_pixel(8'd255, 1'b0);
    @(negedge clk);
    pix_valid = 1'b0;
    check("c_presof_busy", busy, 1'b0);
    check("c_presof_image", tpu_image, last_img);
    // Partial frame of 500 pixels, then SOF restart with a full frame
    drive_pixel(8'd255, 1'b1);
    for (int i = 1; i < 500; i++) drive_pixel(8'd255, 1'b0);
    @(negedge clk);
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
    check("c_partial_ready", pix_ready, 1'b1);
    check("c_partial_image_hold", tpu_image, last_img);
    for (int i = 0; i < IMG_BITS; i++) frame_pix[i] = (i % 3 == 0) ? 8'd255 : 8'd0;
    send_frame();
    kick_to_run("c");
    finish_run("c", 10, 4'd1, 1'b0);

    // Timeout: TPU never signals done
    for (int i = 0; i < IMG_BITS; i++) frame_pix[i] = ((i / 32) % 2) ? 8'd200 : 8'd50;
    send_frame();
    kick_to_run("d");
    repeat (99) @(negedge clk);
    check("d_before_timeout_rv", result_valid, 1'b0);
    check("d_before_timeout_busy", busy, 1'b1);
    @(negedge clk);
    check("d_timeout_rv", result_valid, 1'b1);
    check("d_timeout_num", result_num, 4'hE);
    check("d_timeout_err", timeout_err, 1'b1);
    check("d_timeout_ena", tpu_ena, 1'b0);
    @(negedge clk);
    check("d_timeout_rv_end", result_valid, 1'b0);
    check("d_terr_sticky", timeout_err, 1'b1);
    drive_pixel(8'd0, 1'b1);
    @(negedge clk);
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
    check("d_sof_clears_terr", timeout_err, 1'b0);

    // Reset in the middle of RUN aborts silently
    for (int i = 0; i < IMG_BITS; i++) frame_pix[i] = (i % 2) ? 8'd200 : 8'd10;
    send_frame();
    kick_to_run("e");
    repeat (10) @(negedge clk);
    iRst = 1'b1;
    @(negedge clk);
    check("e_rst_ena", tpu_ena, 1'b0);
    check("e_rst_rstn", tpu_rst_n, 1'b1);
    check("e_rst_num", result_num, 4'hF);
    check("e_rst_rv", result_valid, 1'b0);
    check("e_rst_image", tpu_image, '0);
    iRst = 1'b0;
    seen_pulse = 1'b0;
    repeat (5) begin
      @(negedge clk);
      seen_pulse = seen_pulse | result_valid;
    end
    check("e_no_pulse_after_rst", seen_pulse, 1'b0);
    send_frame();
    kick_to_run("f");
    finish_run("f", 3, 4'd2, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety bound on total run time
  initial begin
    #1000000;
    failures++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
